// File: rtl/undo_stack.sv
// undo_stack: LIFO history store for reverse execution.
// Forward writes push the value they destroy; reverse steps pop it back.
// pop_data/pop_valid are registered; count drives empty/full directly.
module undo_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             push_e,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_e,
    output logic [WIDTH-1:0] pop_data,
    output logic             pop_valid,
    output logic [PTR_W:0]   count,
    output logic             empty,
    output logic             full,
    output logic             ovf,
    output logic             unf
);

    localparam logic [PTR_W:0] ONE     = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   cnt_m1;
    logic [PTR_W-1:0] top_idx;
    logic [PTR_W-1:0] wr_idx;
    logic             swap;
    logic             inc;
    logic             dec;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign cnt_m1  = count - ONE;
    // Top index only meaningful when not empty; write index only when not full.
    assign top_idx = cnt_m1[PTR_W-1:0];
    assign wr_idx  = count[PTR_W-1:0];

    // Push+pop on a non-empty stack replaces the top in place.
    assign swap = push_e && pop_e && !empty;
    // A push grows the stack unless full, or unless it is paired with an
    // accepted pop; paired with a rejected pop (empty) it still lands.
    assign inc  = push_e && (pop_e ? empty : !full);
    assign dec  = pop_e && !push_e && !empty;

    // Storage writes; contents are never cleared, only made unreachable.
    always_ff @(posedge clk) begin
        if (clr_n) begin
            if (swap)
                mem[top_idx] <= push_data;
            else if (inc)
                mem[wr_idx] <= push_data;
        end
    end

    // Count, registered pop result and sticky error flags.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            count     <= '0;
            pop_data  <= '0;
            pop_valid <= 1'b0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
        end else begin
            pop_valid <= 1'b0;
            if (pop_e) begin
                if (!empty) begin
                    pop_data  <= mem[top_idx];
                    pop_valid <= 1'b1;
                end else begin
                    unf <= 1'b1;
                end
            end
            if (push_e && !pop_e && full)
                ovf <= 1'b1;
            if (inc)
                count <= count + ONE;
            else if (dec)
                count <= cnt_m1;
        end
    end

endmodule

// File: tb/tb_undo_stack.sv
// tb_undo_stack: directed plan plus randomized traffic against a queue model.
module tb_undo_stack;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int PTR_W = 4;

    logic             clk = 1'b0;
    logic             clr_n;
    logic             push_e;
    logic [WIDTH-1:0] push_data;
    logic             pop_e;
    logic [WIDTH-1:0] pop_data;
    logic             pop_valid;
    logic [PTR_W:0]   count;
    logic             empty;
    logic             full;
    logic             ovf;
    logic             unf;

    undo_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .clr_n(clr_n), .push_e(push_e), .push_data(push_data),
        .pop_e(pop_e), .pop_data(pop_data), .pop_valid(pop_valid),
        .count(count), .empty(empty), .full(full), .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // reference model: a plain queue, back is top of stack
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] m_pd;
    logic             m_pv, m_ovf, m_unf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input logic rn, input logic pu, input logic [WIDTH-1:0] d, input logic po);
        if (!rn) begin
            q.delete();
            m_pd = '0; m_pv = 0; m_ovf = 0; m_unf = 0;
        end else begin
            m_pv = 0;
            if (pu && po) begin
                if (q.size() == 0) begin
                    q.push_back(d);
                    m_unf = 1;
                end else begin
                    m_pd = q.pop_back();
                    q.push_back(d);
                    m_pv = 1;
                end
            end else if (pu) begin
                if (q.size() == DEPTH) m_ovf = 1;
                else q.push_back(d);
            end else if (po) begin
                if (q.size() == 0) m_unf = 1;
                else begin
                    m_pd = q.pop_back();
                    m_pv = 1;
                end
            end
        end
    endtask

    task automatic cyc(input logic pu, input logic [WIDTH-1:0] d, input logic po, input logic rn = 1'b1);
        @(negedge clk);
        clr_n = rn; push_e = pu; push_data = d; pop_e = po;
        @(posedge clk);
        model_step(rn, pu, d, po);
        #1;
        chk("count", 32'(count), 32'(q.size()));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("full",  32'(full),  32'(q.size() == DEPTH));
        chk("pop_valid", 32'(pop_valid), 32'(m_pv));
        chk("pop_data",  32'(pop_data),  32'(m_pd));
        chk("ovf", 32'(ovf), 32'(m_ovf));
        chk("unf", 32'(unf), 32'(m_unf));
    endtask

    task automatic do_reset();
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
    endtask

    initial begin
        clr_n = 1'b0; push_e = 1'b0; push_data = '0; pop_e = 1'b0;

        // 1: reset then idle
        do_reset();
        cyc(0, 0, 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);

        // 2: LIFO order with back-to-back pops
        cyc(1, 8'h11, 0); cyc(1, 8'h22, 0); cyc(1, 8'h33, 0);
        cyc(0, 0, 1); chk("lifo0", 32'(pop_data), 32'h33);
        cyc(0, 0, 1); chk("lifo1", 32'(pop_data), 32'h22);
        cyc(0, 0, 1); chk("lifo2", 32'(pop_data), 32'h11);
        chk("lifo_empty", 32'(empty), 1);

        // 3: fill, overflow, then pop top
        do_reset();
        for (int i = 0; i < DEPTH; i++) cyc(1, WIDTH'(i), 0);
        chk("full_flag", 32'(full), 1);
        cyc(1, 8'hAA, 0);
        chk("ovf_set", 32'(ovf), 1);
        chk("ovf_count", 32'(count), 16);
        cyc(0, 0, 1);
        chk("ovf_top", 32'(pop_data), 32'h0F);

        // 4: underflow from reset, then normal push/pop
        do_reset();
        cyc(0, 0, 1);
        chk("unf_set", 32'(unf), 1);
        chk("unf_pv", 32'(pop_valid), 0);
        cyc(1, 8'h5A, 0);
        cyc(0, 0, 1);
        chk("unf_pd", 32'(pop_data), 32'h5A);
        chk("unf_sticky", 32'(unf), 1);

        // 5: simultaneous push and pop
        do_reset();
        cyc(1, 8'h01, 0); cyc(1, 8'h02, 0);
        cyc(1, 8'h77, 1);
        chk("swap_pd", 32'(pop_data), 32'h02);
        chk("swap_cnt", 32'(count), 2);
        cyc(0, 0, 1);
        chk("swap_top", 32'(pop_data), 32'h77);
        do_reset();
        cyc(1, 8'h44, 1);
        chk("swap_empty_cnt", 32'(count), 1);
        chk("swap_empty_unf", 32'(unf), 1);
        // swap while full: no overflow
        do_reset();
        for (int i = 0; i < DEPTH; i++) cyc(1, WIDTH'(8'h80 + i), 0);
        cyc(1, 8'hEE, 1);
        chk("swap_full_pd", 32'(pop_data), 32'h8F);
        chk("swap_full_ovf", 32'(ovf), 0);

        // 6: reset coincident with a pop drops its result
        do_reset();
        cyc(1, 8'h10, 0); cyc(1, 8'h20, 0);
        cyc(0, 0, 1, 0);
        chk("rstpop_pv", 32'(pop_valid), 0);
        chk("rstpop_pd", 32'(pop_data), 0);
        cyc(0, 0, 1);
        chk("rstpop_unf", 32'(unf), 1);

        // randomized traffic in push-heavy, pop-heavy and mixed phases
        do_reset();
        for (int i = 0; i < 2400; i++) begin
            int pp, po_pct;
            logic rn;
            pp     = (i < 600) ? 80 : (i < 1200) ? 20 : 50;
            po_pct = (i < 600) ? 25 : (i < 1200) ? 80 : 50;
            rn     = ($urandom_range(0, 199) != 0);
            cyc(($urandom_range(0, 99) < pp), WIDTH'($urandom), ($urandom_range(0, 99) < po_pct), rn);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/undo_stack.md
Name: undo_stack

Overview:
- LIFO history store for reverse execution in the reversible datapath.
- Forward direction: when a register is overwritten, its old value is pushed here.
- Reverse direction: values are popped in strict last-in-first-out order and written back to the register they came from.
- Acts as the read-back counterpart of the write-enabled register cells: it returns the values those writes destroyed.

Parameters:
- WIDTH, 8: bit width of each stored value.
- DEPTH, 16: number of entries; must be a power of two and at least 2.
- PTR_W, 4: pointer/count width; must equal log2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clr_n  input  1  synchronous active-low reset; sampled on the rising edge of clk.
- push_e  input  1  push request for this cycle.
- push_data  input  WIDTH  value to push.
- pop_e  input  1  pop request for this cycle.
- pop_data  output  WIDTH  popped value, registered.
- pop_valid  output  1  pop_data holds a fresh value this cycle (one-cycle pulse).
- count  output  PTR_W+1  number of stored entries, 0 to DEPTH.
- empty  output  1  count == 0, combinational from count.
- full  output  1  count == DEPTH, combinational from count.
- ovf  output  1  sticky overflow error.
- unf  output  1  sticky underflow error.

Behaviour:
- Reset (clr_n=0 at a rising edge) sets:
  - count=0, pop_data=0, pop_valid=0, ovf=0, unf=0.
  - Storage array is not cleared; its contents are unreachable after reset.
  - Reset overrides any push_e/pop_e in the same cycle.
  - Reset during an in-flight pop drops that pop's result (pop_valid=0 on the next cycle).
- Storage: array mem[0..DEPTH-1]. Top of stack is mem[count-1]. There is no wrap-around; count saturates at DEPTH and at 0.
- Push only (push_e=1, pop_e=0):
  - Not full: mem[count] <= push_data; count <= count+1.
  - Full: push dropped, count unchanged, ovf <= 1.
- Pop only (pop_e=1, push_e=0):
  - Not empty: pop_data <= mem[count-1]; pop_valid <= 1; count <= count-1.
  - Empty: pop_data holds its value, pop_valid <= 0, unf <= 1.
- Push and pop in the same cycle:
  - Not empty (including full): pop_data <= old top mem[count-1]; mem[count-1] <= push_data; pop_valid <= 1; count unchanged; no ovf.
  - Empty: the push is performed (count <= 1); the pop is rejected (pop_valid <= 0, unf <= 1). There is no bypass of push_data to pop_data.
- Latency:
  - pop_data and pop_valid appear on the cycle after the pop_e edge.
  - A pushed value is poppable on the very next cycle.
  - Back-to-back pops every cycle are supported, one value per cycle.
- pop_valid is 0 on any cycle not preceded by an accepted pop.
- pop_data holds its last value when pop_valid=0.
- ovf and unf stay set until reset; they do not block further operations.
- Arithmetic:
  - count is PTR_W+1 bits unsigned.
  - Index count-1 is taken only when count>0.
  - Index count is taken only when count<DEPTH.

Test Plan:
1. Reset then idle: clr_n=0 for 2 cycles, then release. Required: count=0, empty=1, full=0, pop_valid=0, pop_data=0, ovf=0, unf=0.
2. LIFO order: push 0x11, 0x22, 0x33 on consecutive cycles, then pop three times back-to-back. Required: pop_data 0x33, 0x22, 0x11 on the cycles after each pop, pop_valid=1 each time, final count=0, empty=1.
3. Full/overflow (DEPTH=16): push 0x00..0x0F, then push 0xAA. Required: full=1 after the 16th push; 0xAA dropped; ovf=1; count=16. Next pop returns 0x0F.
4. Underflow: from reset, pop_e=1 for one cycle. Required: pop_valid=0, pop_data=0, unf=1, count=0. Then push 0x5A and pop. Required: pop_data=0x5A, pop_valid=1, unf still 1.
5. Simultaneous ops:
   - Stack holds [0x01,0x02]; push 0x77 and pop together. Required: pop_data=0x02, pop_valid=1, count=2; next pop returns 0x77.
   - When empty, push 0x44 and pop together. Required: count=1, pop_valid=0, unf=1.
6. Reset mid-operation: push 0x10, 0x20; assert clr_n=0 in the same cycle as a pop. Required: next cycle pop_valid=0, count=0, pop_data=0. A following pop sets unf=1.
